apb_irq_fetch: RTL and testbench
================================

# apb_irq_fetch

APB initiator that services an interrupt line from an APB event/interrupt unit. When `irq_i` is high it issues an APB read of the unit's acknowledge register and converts the returned one-hot word into an event index. The index is delivered to a core-side consumer over a valid/ready port. It sits between the peripheral interconnect and a small controller or core that wants event IDs rather than raw bit masks.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width.
- `ACK_OFFSET`, 12'h008, address driven on `PADDR` for every read (acknowledge register).
- `HOLDOFF`, 2, idle cycles enforced after each completed read before the next may start (0..15).
- `HCLK` in 1: sole clock, all logic on rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `PADDR` out `APB_ADDR_WIDTH`: `ACK_OFFSET` while `PSEL`=1, else 0.
- `PWDATA` out 32: constant 0.
- `PWRITE` out 1: constant 0 (read-only initiator).
- `PSEL` out 1: APB select.
- `PENABLE` out 1: APB enable.
- `PRDATA` in 32: read data.
- `PREADY` in 1: transfer completion.
- `PSLVERR` in 1: slave error, sampled with `PREADY`.
- `irq_i` in 1: level interrupt request from the event unit.
- `evt_valid_o` out 1: event index available.
- `evt_id_o` out 5: index of the highest set bit of the read word.
- `evt_ready_i` in 1: consumer accepts the index.
- `err_o` out 1: one-cycle pulse on a `PSLVERR` completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- **IDLE:** go to SETUP when `irq_i`=1 and the output buffer is not full. Otherwise stay.
- **SETUP:** `PSEL`=1, `PENABLE`=0. Always go to ACCESS next cycle.
- **ACCESS:** `PSEL`=1, `PENABLE`=1. Stay while `PREADY`=0. On `PREADY`=1, go to HOLD, or to IDLE if `HOLDOFF`=0.
  - `PSLVERR`=1: pulse `err_o`, discard data.
  - `PRDATA`=0: spurious, nothing pushed.
  - Otherwise: push the index of the highest set bit of `PRDATA`. Multiple set bits are legal; the highest wins.
- **HOLD:** count down `HOLDOFF` cycles, then go to IDLE. This gives the event unit time to clear and reload its acknowledge register before the next read.
- Buffer space is checked only at SETUP entry. Only one read is ever in flight, so a push at completion always has room.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- `irq_i` dropping during SETUP/ACCESS does not abort the transfer.
- Reset: FSM to IDLE, buffer emptied, holdoff counter cleared.
  - All outputs 0: `PSEL`, `PENABLE`, `PADDR`, `PWDATA`, `PWRITE`, `evt_valid_o`, `evt_id_o`, `err_o`.
  - A reset mid-transfer drops `PSEL` immediately (asynchronous).

## Timing
- APB outputs are decoded from registered state and are glitch-free.
- Zero-wait read: `irq_i` high in IDLE at cycle N.
  - SETUP at N+1, ACCESS at N+2.
  - `evt_valid_o`=1 from N+3. `err_o` pulses in N+3 on error.
- Each `PREADY`=0 cycle in ACCESS adds one cycle of latency.
- Next SETUP is no earlier than N+3+`HOLDOFF` while `irq_i` stays high.
- `evt_id_o` is stable while `evt_valid_o`=1 and `evt_ready_i`=0.
- Pop happens on `evt_valid_o`&&`evt_ready_i` at a rising edge.

## Configuration
- `IRQ_FETCH_FIFO_EN` defined: the output buffer is a 4-entry FIFO.
  - Fetching continues until 4 indices are queued.
  - With an empty FIFO, a pushed entry appears on `evt_valid_o` the cycle after push.
- Undefined: the buffer is a single register.
  - IDLE does not start a read while `evt_valid_o`=1, even if `evt_ready_i`=1 that cycle.
  - The read starts the cycle after the pop.

## Structure
- Package `irq_fetch_pkg`:
  - FSM state enum.
  - `EVT_ID_W`=5.
  - `FIFO_DEPTH`=4.
  - Highest-set-bit index function (returns 0 for input 0; the caller gates on zero).
- Sub-module `irq_fetch_fifo`: parameterised depth/width, push/pop/full/empty, synchronous, same clock and reset. Instantiated only under `IRQ_FETCH_FIFO_EN`.

## Test plan
- `irq_i`=1, slave zero-wait, `PRDATA`=32'h0000_0100 → `PSEL` at N+1, `PENABLE` at N+2, `evt_valid_o`=1 with `evt_id_o`=8 at N+3.
- `PRDATA`=32'h8000_0001 with 3 wait states → `evt_id_o`=31, valid at N+6. A second read does not start before `HOLDOFF` cycles elapse.
- `PSLVERR`=1 on completion → `err_o` high exactly 1 cycle, no push, FSM returns via HOLD.
- `PRDATA`=0 → no push, `err_o`=0, next read after holdoff if `irq_i` still high.
- `evt_ready_i`=0 with `irq_i` held high:
  - FIFO build: exactly 4 reads, then `PSEL` stays 0. Raising `evt_ready_i` pops IDs in order and reads resume.
  - Non-FIFO build: exactly 1 read.
- `HRESETn` asserted during ACCESS → `PSEL`/`PENABLE`/`evt_valid_o` 0 immediately. After release, no transfer until `irq_i` is seen in IDLE.

Source files
------------

// File: rtl/irq_fetch_pkg.sv
// Shared types and helpers for the APB interrupt-acknowledge fetcher.
// The optional IRQ_FETCH_FIFO_EN build uses FIFO_DEPTH for the event buffer.
package irq_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } fetch_state_e;

  localparam int EVT_ID_W   = 5;
  localparam int FIFO_DEPTH = 4;

  // Index of the highest set bit; 0 for a zero word, callers gate on zero.
  function automatic logic [EVT_ID_W-1:0] highest_set_bit(input logic [31:0] word);
    logic [EVT_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (word[i]) idx = EVT_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_fetch_fifo.sv
// Small synchronous FIFO for event indices; push when full and pop when
// empty are ignored.
module irq_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_irq_fetch.sv
// APB read initiator: on irq_i reads the acknowledge register and delivers the
// highest set bit as an event index. Define IRQ_FETCH_FIFO_EN for a 4-deep buffer.
module apb_irq_fetch
  import irq_fetch_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter logic [APB_ADDR_WIDTH-1:0] ACK_OFFSET     = 12'h008,
  parameter int                        HOLDOFF        = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic                      irq_i,
  output logic                      evt_valid_o,
  output logic [EVT_ID_W-1:0]       evt_id_o,
  input  logic                      evt_ready_i,
  output logic                      err_o
);

  localparam logic [3:0] HOLD_LOAD = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  fetch_state_e        r_state;
  fetch_state_e        w_next;
  logic [3:0]          r_hold_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_err;
  logic                w_complete;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic [EVT_ID_W-1:0] w_push_id;

  // Event port: an index transfers on a rising edge with evt_valid_o && evt_ready_i;
  // evt_valid_o never drops and evt_id_o never changes until that transfer.
  assign w_complete = (r_state == ST_ACCESS) && PREADY;
  assign w_push     = w_complete && !PSLVERR && (PRDATA != 32'd0);
  assign w_push_id  = highest_set_bit(PRDATA);
  assign w_pop      = evt_valid_o && evt_ready_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (irq_i && !w_full) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (PREADY) w_next = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD:   if (r_hold_cnt == 4'd0) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // APB strobes are registered from the next state so they come straight off flops.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_hold_cnt <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_psel    <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable <= (w_next == ST_ACCESS);
      r_err     <= w_complete && PSLVERR;
      if (w_complete) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != 4'd0)) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PADDR   = r_psel ? ACK_OFFSET : '0;
  assign PWDATA  = 32'd0;
  assign PWRITE  = 1'b0;
  assign err_o   = r_err;

`ifdef IRQ_FETCH_FIFO_EN
  logic w_empty;

  irq_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_ID_W)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .i_push  (w_push),
    .i_data  (w_push_id),
    .i_pop   (w_pop),
    .o_data  (evt_id_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid_o = !w_empty;
`else
  logic                r_valid;
  logic [EVT_ID_W-1:0] r_id;

  // A read only starts with the register empty, so push and pop never collide.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_id    <= '0;
    end else if (w_push) begin
      r_valid <= 1'b1;
      r_id    <= w_push_id;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_id_o    = r_id;
  assign w_full      = r_valid;
`endif

endmodule

// File: tb/tb_apb_irq_fetch.sv
// Bench for apb_irq_fetch: APB slave model, event scoreboard, scenario tasks.
// Works for both the default build and IRQ_FETCH_FIFO_EN.
module tb_apb_irq_fetch;

  localparam int          HOLDOFF = 2;
  localparam logic [11:0] ACK     = 12'h008;
`ifdef IRQ_FETCH_FIFO_EN
  localparam int BUF_SLOTS = 4;
`else
  localparam int BUF_SLOTS = 1;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        irq_i = 1'b0;
  logic        evt_valid_o;
  logic [4:0]  evt_id_o;
  logic        evt_ready_i = 1'b0;
  logic        err_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int xfers = 0;
  int err_seen = 0;
  int slv_waits = 0;
  bit slv_rand = 1'b0;
  int acc_cnt = 0;

  logic [31:0] rd_q[$];
  logic        er_q[$];
  logic [4:0]  exp_q[$];
  int          setup_q[$];
  logic [4:0]  exp_id;

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  apb_irq_fetch #(
    .APB_ADDR_WIDTH (12),
    .ACK_OFFSET     (ACK),
    .HOLDOFF        (HOLDOFF)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .irq_i       (irq_i),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .err_o       (err_o)
  );

  // ---------------- APB slave model ----------------
  always @(negedge HCLK) begin
    if (PSEL && PENABLE) begin
      if (acc_cnt == 0 && slv_rand) slv_waits = $urandom_range(0, 3);
      if (acc_cnt >= slv_waits) begin
        PREADY = 1'b1;
        if (rd_q.size() > 0) begin
          PRDATA  = rd_q.pop_front();
          PSLVERR = er_q.pop_front();
        end else begin
          PRDATA  = 32'd0;
          PSLVERR = 1'b0;
        end
        xfers++;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
    end
  end

  // ---------------- monitors and scoreboard ----------------
  always @(negedge HCLK) begin
    #2;
    if (HRESETn) begin
      if (PSEL && !PENABLE) setup_q.push_back(cyc);
      if (err_o) err_seen++;
      if (evt_valid_o && evt_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt_unexpected: got id %0d, expected no event", evt_id_o);
        end else begin
          exp_id = exp_q.pop_front();
          if (evt_id_o !== exp_id) begin
            n_fail++;
            $display("FAIL evt_id: got %0d, expected %0d", evt_id_o, exp_id);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_id(input logic [31:0] w);
    logic [31:0] v;
    int n;
    v = w;
    n = 0;
    while (v > 32'd1) begin
      v = v >> 1;
      n++;
    end
    return 5'(n);
  endfunction

  function automatic logic [31:0] rand_word();
    int b;
    logic [31:0] one;
    logic [31:0] low;
    b   = $urandom_range(0, 31);
    one = 32'h1 << b;
    low = $urandom;
    return one | (low & (one - 32'h1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic queue_word(input logic [31:0] w, input logic e);
    rd_q.push_back(w);
    er_q.push_back(e);
    if (!e && (w != 32'd0)) exp_q.push_back(ref_id(w));
  endtask

  task automatic wait_fetched(input int max);
    int k;
    k = 0;
    while (rd_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_timeout: %0d words unread, expected 0", rd_q.size());
      rd_q.delete();
      er_q.delete();
    end
  endtask

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    evt_ready_i = 1'b1;
    while ((exp_q.size() != 0 || evt_valid_o) && k < max) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || evt_valid_o) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d events pending valid=%0b, expected 0", exp_q.size(), evt_valid_o);
      exp_q.delete();
    end
    evt_ready_i = 1'b0;
    for (int i = 0; i < HOLDOFF + 3; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({PSEL, PENABLE, PADDR, PWDATA, PWRITE, evt_valid_o, evt_id_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: psel=%0b pen=%0b paddr=%h valid=%0b id=%0d err=%0b, expected all 0",
               PSEL, PENABLE, PADDR, evt_valid_o, evt_id_o, err_o);
    end
    HRESETn = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({PSEL, evt_valid_o, err_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: psel=%0b valid=%0b err=%0b, expected 0 0 0", PSEL, evt_valid_o, err_o);
    end
  endtask

  task automatic test_zero_wait();
    slv_waits = 0;
    slv_rand = 1'b0;
    evt_ready_i = 1'b0;
    queue_word(32'h0000_0100, 1'b0);
    irq_i = 1'b1;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b10 || PADDR !== ACK || PWRITE !== 1'b0 || PWDATA !== 32'd0) begin
      n_fail++;
      $display("FAIL zw_setup: psel=%0b pen=%0b paddr=%h pwrite=%0b, expected 1 0 %h 0",
               PSEL, PENABLE, PADDR, PWRITE, ACK);
    end
    irq_i = 1'b0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11 || PADDR !== ACK) begin
      n_fail++;
      $display("FAIL zw_access: psel=%0b pen=%0b paddr=%h, expected 1 1 %h", PSEL, PENABLE, PADDR, ACK);
    end
    tick();
    n_cmp++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 5'd8 || err_o !== 1'b0 || PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_result: valid=%0b id=%0d err=%0b psel=%0b, expected 1 8 0 0",
               evt_valid_o, evt_id_o, err_o, PSEL);
    end
    wait_drain(20);
  endtask

  task automatic test_wait_states();
    slv_waits = 3;
    evt_ready_i = 1'b0;
    queue_word(32'h8000_0001, 1'b0);
    irq_i = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (evt_valid_o !== 1'b0 || {PSEL, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL ws_pending: valid=%0b psel=%0b pen=%0b, expected 0 1 1", evt_valid_o, PSEL, PENABLE);
    end
    tick();
    n_cmp++;
    if (evt_valid_o !== 1'b1 || evt_id_o !== 5'd31 || PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL ws_result: valid=%0b id=%0d psel=%0b, expected 1 31 0", evt_valid_o, evt_id_o, PSEL);
    end
    for (int h = 1; h <= HOLDOFF; h++) begin
      tick();
      n_cmp++;
      if (PSEL !== 1'b0) begin
        n_fail++;
        $display("FAIL ws_holdoff: psel=%0b at holdoff cycle %0d, expected 0", PSEL, h);
      end
    end
    irq_i = 1'b0;
    slv_waits = 0;
    wait_drain(40);
  endtask

  task automatic test_slverr();
    int e0;
    int s0;
    e0 = err_seen;
    s0 = setup_q.size();
    slv_waits = 0;
    evt_ready_i = 1'b1;
    queue_word(32'h0000_0004, 1'b1);
    queue_word(32'h0000_0010, 1'b0);
    irq_i = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (err_o !== 1'b1 || evt_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: err=%0b valid=%0b, expected 1 0", err_o, evt_valid_o);
    end
    tick();
    n_cmp++;
    if (err_o !== 1'b0 || PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width: err=%0b psel=%0b, expected 0 0", err_o, PSEL);
    end
    wait_fetched(100);
    irq_i = 1'b0;
    wait_drain(40);
    n_cmp++;
    if (err_seen - e0 != 1) begin
      n_fail++;
      $display("FAIL err_count: got %0d pulses, expected 1", err_seen - e0);
    end
    n_cmp++;
    if (setup_q.size() - s0 != 2 || setup_q[s0 + 1] - setup_q[s0] != 3 + HOLDOFF) begin
      n_fail++;
      $display("FAIL err_gap: %0d setups gap %0d, expected 2 setups gap %0d",
               setup_q.size() - s0, (setup_q.size() - s0 == 2) ? setup_q[s0 + 1] - setup_q[s0] : -1,
               3 + HOLDOFF);
    end
  endtask

  task automatic test_spurious();
    int e0;
    int s0;
    int x0;
    e0 = err_seen;
    s0 = setup_q.size();
    x0 = xfers;
    evt_ready_i = 1'b0;
    queue_word(32'd0, 1'b0);
    queue_word(32'd0, 1'b0);
    irq_i = 1'b1;
    wait_fetched(100);
    irq_i = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (evt_valid_o !== 1'b0 || err_seen != e0 || xfers - x0 != 2) begin
      n_fail++;
      $display("FAIL spur_result: valid=%0b errs=%0d reads=%0d, expected 0 0 2",
               evt_valid_o, err_seen - e0, xfers - x0);
    end
    n_cmp++;
    if (setup_q.size() - s0 != 2 || setup_q[s0 + 1] - setup_q[s0] != 3 + HOLDOFF) begin
      n_fail++;
      $display("FAIL spur_gap: %0d setups gap %0d, expected 2 setups gap %0d",
               setup_q.size() - s0, (setup_q.size() - s0 == 2) ? setup_q[s0 + 1] - setup_q[s0] : -1,
               3 + HOLDOFF);
    end
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    int x0;
    x0 = xfers;
    evt_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) queue_word(rand_word(), 1'b0);
    irq_i = 1'b1;
    repeat (40) tick();
    n_cmp++;
    if (xfers - x0 != BUF_SLOTS || PSEL !== 1'b0 || evt_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: reads=%0d psel=%0b valid=%0b, expected %0d 0 1",
               xfers - x0, PSEL, evt_valid_o, BUF_SLOTS);
    end
    evt_ready_i = 1'b1;
    wait_fetched(200);
    irq_i = 1'b0;
    wait_drain(60);
    n_cmp++;
    if (xfers - x0 != 6) begin
      n_fail++;
      $display("FAIL bp_resume: reads=%0d, expected 6", xfers - x0);
    end
  endtask

  task automatic test_random();
    int x0;
    int e0;
    int exp_errs;
    int k;
    int kind;
    x0 = xfers;
    e0 = err_seen;
    exp_errs = 0;
    slv_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        queue_word($urandom, 1'b1);
        exp_errs++;
      end else if (kind == 1) begin
        queue_word(32'd0, 1'b0);
      end else begin
        queue_word(rand_word(), 1'b0);
      end
    end
    irq_i = 1'b1;
    k = 0;
    while (rd_q.size() != 0 && k < 3000) begin
      evt_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    wait_fetched(10);
    irq_i = 1'b0;
    wait_drain(80);
    slv_rand = 1'b0;
    slv_waits = 0;
    n_cmp++;
    if (xfers - x0 != 24 || err_seen - e0 != exp_errs) begin
      n_fail++;
      $display("FAIL rand_counts: reads=%0d errs=%0d, expected 24 %0d", xfers - x0, err_seen - e0, exp_errs);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    slv_waits = 5;
    evt_ready_i = 1'b0;
    queue_word(32'h0000_0040, 1'b0);
    irq_i = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre: psel=%0b pen=%0b, expected 1 1", PSEL, PENABLE);
    end
    #1 HRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, evt_valid_o, err_o} !== 4'b0000 || PADDR !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_async: psel=%0b pen=%0b valid=%0b paddr=%h, expected 0 0 0 000",
               PSEL, PENABLE, evt_valid_o, PADDR);
    end
    irq_i = 1'b0;
    slv_waits = 0;
    rd_q.delete();
    er_q.delete();
    exp_q.delete();
    repeat (2) tick();
    HRESETn = 1'b1;
    s0 = setup_q.size();
    repeat (6) tick();
    n_cmp++;
    if (setup_q.size() != s0 || PSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet: %0d setups psel=%0b, expected 0 0", setup_q.size() - s0, PSEL);
    end
    queue_word(32'h0000_0002, 1'b0);
    irq_i = 1'b1;
    wait_fetched(40);
    irq_i = 1'b0;
    wait_drain(40);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slverr();
    test_spurious();
    test_backpressure();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d events never delivered, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
